// File: rtl/fft16_ctrl.sv
// fft16_ctrl: address/twiddle sequencer for a 16-point radix-2 DIT FFT.
// Four stages of eight butterflies. Each stage issues its butterflies, then
// drains the datapath before the next stage begins. Write-back addresses are
// the issue addresses delayed by PIPE_LAT cycles.
// Optional feature: define FFT_CTRL_INVERSE_EN to add the 'inverse' input,
// which conjugates the twiddles for an inverse transform.
//
// Handshake: start is a single-cycle request that is accepted only while the
// FSM is idle; all other start pulses are dropped. rd_en and wr_en are
// fire-and-forget strobes with no back-pressure. done pulses once per
// accepted start, unless a reset intervenes.
module fft16_ctrl #(
    parameter int PIPE_LAT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
`ifdef FFT_CTRL_INVERSE_EN
    input  logic       inverse,
`endif
    output logic       rd_en,
    output logic [3:0] rd_addr_a,
    output logic [3:0] rd_addr_b,
    output logic [7:0] tw_re_code,
    output logic [7:0] tw_im_code,
    output logic       tw_re_neg,
    output logic       tw_im_neg,
    output logic       tw_re_zero,
    output logic       tw_im_zero,
    output logic       wr_en,
    output logic [3:0] wr_addr_a,
    output logic [3:0] wr_addr_b,
    output logic [1:0] stage,
    output logic       busy,
    output logic       done,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] DRAIN_LAST = 4'(PIPE_LAT - 1);

    state_t     state, state_nxt;
    logic [2:0] bfly;
    logic [1:0] stg;
    logic [3:0] dcnt;

    // Combinational issue values, registered onto the outputs one cycle later
    logic       issue;
    logic [2:0] pmask, pos, grp, k;
    logic [3:0] span, addr_a, addr_b;
    logic [7:0] re_code, im_code;
    logic       re_neg, im_neg, re_zero, im_zero;

    logic [8:0] dl [PIPE_LAT];

`ifdef FFT_CTRL_INVERSE_EN
    logic inv_q;

    // Capture the transform direction together with an accepted start
    always_ff @(posedge clk) begin
        if (!rst_n)
            inv_q <= 1'b0;
        else if (state == S_IDLE && start)
            inv_q <= inverse;
    end
`endif

    // State register plus butterfly, stage and drain counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            bfly  <= 3'd0;
            stg   <= 2'd0;
            dcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    bfly <= 3'd0;
                    stg  <= 2'd0;
                    dcnt <= 4'd0;
                end
                S_RUN: begin
                    bfly <= bfly + 3'd1;
                    dcnt <= 4'd0;
                end
                S_DRAIN: begin
                    dcnt <= dcnt + 4'd1;
                    if (state_nxt == S_RUN)
                        stg <= stg + 2'd1;
                end
                default: begin
                    stg <= 2'd0;
                end
            endcase
        end
    end

    // Next-state logic: issue 8 butterflies, drain PIPE_LAT cycles, repeat x4
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (bfly == 3'd7) state_nxt = S_DRAIN;
            S_DRAIN: if (dcnt == DRAIN_LAST)
                         state_nxt = (stg == 2'd3) ? S_DONE : S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: butterfly addresses and twiddle descriptor for the current issue
    always_comb begin
        issue   = (state == S_RUN);
        span    = 4'd1 << stg;
        pmask   = 3'(span - 4'd1);
        pos     = bfly & pmask;
        grp     = bfly >> stg;
        k       = pos << (2'd3 - stg);
        addr_a  = ({grp, 1'b0} << stg) | {1'b0, pos};
        addr_b  = addr_a + span;
        re_code = 8'h00;
        im_code = 8'h00;
        re_neg  = 1'b0;
        im_neg  = 1'b0;
        re_zero = 1'b0;
        im_zero = 1'b0;
        case (k)
            3'd0: begin re_code = 8'h01;                im_zero = 1'b1;                end
            3'd1: begin re_code = 8'hEC;                im_code = 8'h61; im_neg = 1'b1; end
            3'd2: begin re_code = 8'hB5;                im_code = 8'hB5; im_neg = 1'b1; end
            3'd3: begin re_code = 8'h61;                im_code = 8'hEC; im_neg = 1'b1; end
            3'd4: begin re_zero = 1'b1;                 im_code = 8'h01; im_neg = 1'b1; end
            3'd5: begin re_code = 8'h61; re_neg = 1'b1; im_code = 8'hEC; im_neg = 1'b1; end
            3'd6: begin re_code = 8'hB5; re_neg = 1'b1; im_code = 8'hB5; im_neg = 1'b1; end
            default: begin re_code = 8'hEC; re_neg = 1'b1; im_code = 8'h61; im_neg = 1'b1; end
        endcase
`ifdef FFT_CTRL_INVERSE_EN
        // Conjugate twiddle: flip the imaginary sign except where Im(W) is zero
        if (inv_q && k != 3'd0)
            im_neg = ~im_neg;
`endif
    end

    // Registered issue outputs; everything but status is zero between issues
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_en      <= 1'b0;
            rd_addr_a  <= 4'd0;
            rd_addr_b  <= 4'd0;
            tw_re_code <= 8'h00;
            tw_im_code <= 8'h00;
            tw_re_neg  <= 1'b0;
            tw_im_neg  <= 1'b0;
            tw_re_zero <= 1'b0;
            tw_im_zero <= 1'b0;
            stage      <= 2'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            rd_en      <= issue;
            rd_addr_a  <= issue ? addr_a  : 4'd0;
            rd_addr_b  <= issue ? addr_b  : 4'd0;
            tw_re_code <= issue ? re_code : 8'h00;
            tw_im_code <= issue ? im_code : 8'h00;
            tw_re_neg  <= issue & re_neg;
            tw_im_neg  <= issue & im_neg;
            tw_re_zero <= issue & re_zero;
            tw_im_zero <= issue & im_zero;
            stage      <= stg;
            busy       <= (state != S_IDLE);
            done       <= (state == S_DONE);
        end
    end

    // Write-back delay line; shifts every cycle so in-flight writes always land
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++)
                dl[i] <= 9'd0;
        end else begin
            dl[0] <= {rd_en, rd_addr_a, rd_addr_b};
            for (int i = 1; i < PIPE_LAT; i++)
                dl[i] <= dl[i-1];
        end
    end

    assign {wr_en, wr_addr_a, wr_addr_b} = dl[PIPE_LAT-1];
    assign dbg_state = state;

endmodule
